// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: opcodes, FSM states,
// request-size decode and IO write gating.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned CNT_W  = 3;

  localparam logic [1:0] IO_HI_DEF = 2'b11;

  localparam logic [OP_W-1:0] OP_LB  = 6'd1;
  localparam logic [OP_W-1:0] OP_LH  = 6'd2;
  localparam logic [OP_W-1:0] OP_LW  = 6'd3;
  localparam logic [OP_W-1:0] OP_LBU = 6'd4;
  localparam logic [OP_W-1:0] OP_LHU = 6'd5;
  localparam logic [OP_W-1:0] OP_SB  = 6'd6;
  localparam logic [OP_W-1:0] OP_SH  = 6'd7;
  localparam logic [OP_W-1:0] OP_SW  = 6'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_LSB = 1'b0,
    OWN_IF  = 1'b1
  } owner_e;

  // Byte count of an access; zero marks an opcode the controller ignores.
  function automatic logic [CNT_W-1:0] op_size(input logic [OP_W-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = CNT_W'(1);
      OP_LH, OP_LHU, OP_SH: op_size = CNT_W'(2);
      OP_LW, OP_SW:         op_size = CNT_W'(4);
      default:              op_size = CNT_W'(0);
    endcase
  endfunction

  function automatic logic op_is_store(input logic [OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // A write byte may go out unless it targets the IO region while its buffer is full.
  function automatic logic wr_allowed(input logic [1:0] region, input logic [1:0] io_hi,
                                      input logic full);
    return !((region == io_hi) && full);
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial responder for LSB loads/stores and instruction fetches over the
// single 8-bit RAM/IO port; assembles little-endian data and pulses done.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned AW    = ADDR_W,
  parameter logic [1:0]  IO_HI = IO_HI_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              lsb_req,
  input  logic [AW-1:0]     lsb_addr,
  input  logic [OP_W-1:0]   lsb_op,
  input  logic [DATA_W-1:0] lsb_wdata,
  output logic [DATA_W-1:0] lsb_rdata,
  output logic              lsb_ok,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ok,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [AW-1:0]     mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  state_e            state, state_d;
  owner_e            owner, owner_d;
  logic [CNT_W-1:0]  cnt, cnt_d, size, size_d, cap_idx, cap_idx_d;
  logic [AW-1:0]     addr, addr_d, mem_a_d;
  logic [DATA_W-1:0] wdata, wdata_d, data, data_d;
  logic [DATA_W-1:0] lsb_rdata_d, if_rdata_d;
  logic              rd_live, rd_live_d, cap_valid, cap_valid_d;
  logic              lsb_ok_d, if_ok_d, mem_wr_d;
  logic [7:0]        mem_dout_d;

  logic              take_lsb, take_if;
  logic [AW-1:0]     req_a, nxt_a;
  logic [CNT_W-1:0]  nxt;
  logic [DATA_W-1:0] merged;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    cnt_d       = cnt;
    size_d      = size;
    cap_idx_d   = cap_idx;
    cap_valid_d = cap_valid;
    rd_live_d   = rd_live;
    addr_d      = addr;
    wdata_d     = wdata;
    data_d      = data;
    mem_a_d     = mem_a;
    mem_dout_d  = mem_dout;
    mem_wr_d    = mem_wr;
    lsb_rdata_d = lsb_rdata;
    if_rdata_d  = if_rdata;
    lsb_ok_d    = 1'b0;
    if_ok_d     = 1'b0;

    take_lsb = lsb_req && !lsb_ok && (op_size(lsb_op) != '0);
    take_if  = !take_lsb && if_req && !if_ok;
    req_a    = take_lsb ? lsb_addr : if_addr;
    nxt      = cnt + CNT_W'(1);
    nxt_a    = addr + AW'(nxt);
    merged   = data | (DATA_W'(mem_din) << {cap_idx, 3'b000});

    if (!rdy) begin
      // Frozen: drop any in-flight capture and re-issue its byte after resume.
      mem_wr_d = 1'b0;
      if (state == ST_READ && cap_valid) begin
        cap_valid_d = 1'b0;
        rd_live_d   = 1'b1;
        cnt_d       = cap_idx;
        mem_a_d     = addr + AW'(cap_idx);
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_lsb || take_if) begin
            addr_d      = req_a;
            mem_a_d     = req_a;
            cnt_d       = '0;
            data_d      = '0;
            cap_valid_d = 1'b0;
            wdata_d     = lsb_wdata;
            owner_d     = take_lsb ? OWN_LSB : OWN_IF;
            size_d      = take_lsb ? op_size(lsb_op) : CNT_W'(4);
            if (take_lsb && op_is_store(lsb_op)) begin
              state_d    = ST_WRITE;
              mem_dout_d = lsb_wdata[7:0];
              mem_wr_d   = wr_allowed(req_a[17:16], IO_HI, io_buffer_full);
            end else begin
              state_d   = ST_READ;
              rd_live_d = 1'b1;
              mem_wr_d  = 1'b0;
            end
          end
        end
        ST_READ: begin
          cap_valid_d = rd_live;
          cap_idx_d   = cnt;
          if (rd_live) begin
            if (nxt == size) begin
              rd_live_d = 1'b0;
            end else begin
              cnt_d   = nxt;
              mem_a_d = nxt_a;
            end
          end
          if (cap_valid) begin
            data_d = merged;
            if (cap_idx == size - CNT_W'(1)) begin
              state_d = ST_IDLE;
              if (owner == OWN_LSB) begin
                lsb_rdata_d = merged;
                lsb_ok_d    = 1'b1;
              end else begin
                if_rdata_d = merged;
                if_ok_d    = 1'b1;
              end
            end
          end
        end
        ST_WRITE: begin
          // mem_wr low means the current byte was held back; retry it.
          if (!mem_wr) begin
            mem_wr_d = wr_allowed(mem_a[17:16], IO_HI, io_buffer_full);
          end else if (nxt == size) begin
            state_d  = ST_IDLE;
            mem_wr_d = 1'b0;
            lsb_ok_d = 1'b1;
          end else begin
            cnt_d      = nxt;
            mem_a_d    = nxt_a;
            mem_dout_d = 8'(wdata >> {nxt, 3'b000});
            mem_wr_d   = wr_allowed(nxt_a[17:16], IO_HI, io_buffer_full);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_LSB;
      cnt       <= '0;
      size      <= '0;
      cap_idx   <= '0;
      cap_valid <= 1'b0;
      rd_live   <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      data      <= '0;
      mem_a     <= '0;
      mem_dout  <= '0;
      mem_wr    <= 1'b0;
      lsb_rdata <= '0;
      if_rdata  <= '0;
      lsb_ok    <= 1'b0;
      if_ok     <= 1'b0;
    end else begin
      owner     <= owner_d;
      cnt       <= cnt_d;
      size      <= size_d;
      cap_idx   <= cap_idx_d;
      cap_valid <= cap_valid_d;
      rd_live   <= rd_live_d;
      addr      <= addr_d;
      wdata     <= wdata_d;
      data      <= data_d;
      mem_a     <= mem_a_d;
      mem_dout  <= mem_dout_d;
      mem_wr    <= mem_wr_d;
      lsb_rdata <= lsb_rdata_d;
      if_rdata  <= if_rdata_d;
      lsb_ok    <= lsb_ok_d;
      if_ok     <= if_ok_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-addressed RAM beside the DUT, plus a
// reference memory model that predicts load data, write traffic and latency.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, lsb_req, if_req, lsb_ok, if_ok, mem_wr, io_buffer_full;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata, if_addr, if_rdata, mem_a;
  logic [5:0]  lsb_op;
  logic [7:0]  mem_din, mem_dout;

  int checks = 0;
  int errors = 0;

  logic [7:0]  bus_ram [logic [31:0]];
  logic [7:0]  mdl     [logic [31:0]];
  logic [39:0] wlog[$];
  logic [39:0] exp_log[$];
  logic [5:0]  ops [8];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_op(lsb_op), .lsb_wdata(lsb_wdata),
    .lsb_rdata(lsb_rdata), .lsb_ok(lsb_ok),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ok(if_ok),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seed_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return bus_ram.exists(a) ? bus_ram[a] : seed_byte(a);
  endfunction

  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : seed_byte(a);
  endfunction

  function automatic int size_of(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  // Registered-read RAM; every write that reaches the bus is logged.
  always @(posedge clk) begin
    mem_din <= bus_rd(mem_a);
    if (mem_wr) begin
      bus_ram[mem_a] = mem_dout;
      wlog.push_back({mem_a, mem_dout});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    bus_ram[a] = d;
    mdl[a]     = d;
  endtask

  task automatic check_log(input string tag);
    check({tag, "_nwr"}, 64'(wlog.size()), 64'(exp_log.size()));
    for (int i = 0; i < wlog.size() && i < exp_log.size(); i++)
      check({tag, "_wr"}, 64'(wlog[i]), 64'(exp_log[i]));
    wlog.delete();
    exp_log.delete();
  endtask

  // One LSB transaction; IO buffer held full for the first `stall` cycles.
  task automatic run_lsb(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input int stall);
    int n, lat, k;
    bit st, seen;
    logic [31:0] exp;
    n = size_of(op);
    st = (op == OP_SB || op == OP_SH || op == OP_SW);
    exp = '0;
    wlog.delete();
    exp_log.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] ba;
      ba = a + 32'(i);
      if (st) begin
        mdl[ba] = wd[8*i +: 8];
        exp_log.push_back({ba, wd[8*i +: 8]});
      end else begin
        exp |= 32'(mdl_rd(ba)) << (8 * i);
      end
    end
    lat = (st ? n + 1 : n + 2) + stall;
    lsb_op = op; lsb_addr = a; lsb_wdata = wd; lsb_req = 1'b1;
    if (stall > 0) io_buffer_full = 1'b1;
    k = 0; seen = 0;
    while (!seen && k < lat + 20) begin
      @(negedge clk);
      k++;
      if (stall > 0 && k <= stall) check("io_stall_wr", 64'(mem_wr), 64'(0));
      if (stall > 0 && k == stall) io_buffer_full = 1'b0;
      if (lsb_ok) begin
        seen = 1;
        check("lsb_lat", 64'(k), 64'(lat));
        if (!st) check("lsb_rdata", 64'(lsb_rdata), 64'(exp));
        lsb_req = 1'b0;
      end
    end
    if (!seen) check("lsb_timeout", 64'(0), 64'(1));
    @(negedge clk);
    check("lsb_ok_pulse", 64'(lsb_ok), 64'(0));
    check_log(st ? "store" : "load");
  endtask

  task automatic run_if(input logic [31:0] a);
    int k;
    bit seen;
    logic [31:0] exp;
    exp = '0;
    for (int i = 0; i < 4; i++) exp |= 32'(mdl_rd(a + 32'(i))) << (8 * i);
    if_addr = a; if_req = 1'b1;
    k = 0; seen = 0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (if_ok) begin
        seen = 1;
        check("if_lat", 64'(k), 64'(6));
        check("if_rdata", 64'(if_rdata), 64'(exp));
        if_req = 1'b0;
      end
    end
    if (!seen) check("if_timeout", 64'(0), 64'(1));
    @(negedge clk);
    check("if_ok_pulse", 64'(if_ok), 64'(0));
  endtask

  initial begin
    int k, nok, nwr;
    bit seen_l, seen_f;
    logic [31:0] exp_l, exp_f;

    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    rst = 1'b1; rdy = 1'b1; lsb_req = 1'b0; if_req = 1'b0; io_buffer_full = 1'b0;
    lsb_addr = '0; lsb_op = '0; lsb_wdata = '0; if_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_lsb_ok", 64'(lsb_ok), 64'(0));
    check("rst_if_ok", 64'(if_ok), 64'(0));
    check("rst_mem_wr", 64'(mem_wr), 64'(0));
    check("rst_mem_a", 64'(mem_a), 64'(0));
    check("rst_mem_dout", 64'(mem_dout), 64'(0));
    check("rst_lsb_rdata", 64'(lsb_rdata), 64'(0));
    check("rst_if_rdata", 64'(if_rdata), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    run_lsb(OP_LW, 32'h100, '0, 0);
    check("lw_word", 64'(lsb_rdata), 64'(32'h44332211));
    poke(32'h200, 8'h80);
    run_lsb(OP_LB, 32'h200, '0, 0);
    check("lb_nosext", 64'(lsb_rdata), 64'(32'h80));
    run_lsb(OP_LH, 32'h202, '0, 0);
    run_lsb(OP_LHU, 32'h201, '0, 0);
    run_lsb(OP_SH, 32'h300, 32'hDEADBEEF, 0);
    run_lsb(OP_LW, 32'h300, '0, 0);
    run_lsb(OP_SB, 32'h30000, 32'h000000A5, 3);
    run_lsb(OP_SW, 32'h30010, 32'h01020304, 0);
    poke(32'hFFFF_FFFF, 8'hC3); poke(32'h0, 8'h3C);
    run_lsb(OP_LW, 32'hFFFF_FFFE, '0, 0);
    run_if(32'h104);

    // Simultaneous requests: LSB first, fetch accepted in the LSB done cycle.
    exp_l = '0; exp_f = '0;
    for (int i = 0; i < 4; i++) begin
      exp_l |= 32'(mdl_rd(32'h10 + 32'(i))) << (8 * i);
      exp_f |= 32'(mdl_rd(32'(i))) << (8 * i);
    end
    lsb_op = OP_LW; lsb_addr = 32'h10; lsb_req = 1'b1; if_addr = 32'h0; if_req = 1'b1;
    k = 0; seen_l = 0; seen_f = 0;
    while (!(seen_l && seen_f) && k < 40) begin
      @(negedge clk);
      k++;
      if (lsb_ok) begin
        seen_l = 1; lsb_req = 1'b0;
        check("dual_lsb_lat", 64'(k), 64'(6));
        check("dual_lsb_rdata", 64'(lsb_rdata), 64'(exp_l));
      end
      if (if_ok) begin
        seen_f = 1; if_req = 1'b0;
        check("dual_if_first", 64'(seen_l), 64'(1));
        check("dual_if_lat", 64'(k), 64'(12));
        check("dual_if_rdata", 64'(if_rdata), 64'(exp_f));
      end
    end
    if (!(seen_l && seen_f)) check("dual_timeout", 64'(0), 64'(1));
    @(negedge clk);

    // Unknown opcode is ignored.
    wlog.delete();
    lsb_op = 6'h3F; lsb_addr = 32'h400; lsb_req = 1'b1; nok = 0;
    repeat (10) begin
      @(negedge clk);
      if (lsb_ok || mem_wr) nok++;
    end
    lsb_req = 1'b0;
    check("bad_op_idle", 64'(nok), 64'(0));
    check("bad_op_nwr", 64'(wlog.size()), 64'(0));

    // rdy pause in the middle of a word load.
    exp_l = '0;
    for (int i = 0; i < 4; i++) exp_l |= 32'(mdl_rd(32'h1200 + 32'(i))) << (8 * i);
    lsb_op = OP_LW; lsb_addr = 32'h1200; lsb_req = 1'b1;
    k = 0; seen_l = 0; nwr = 0;
    while (!seen_l && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 2) rdy = 1'b0;
      if (k == 5) rdy = 1'b1;
      if (mem_wr) nwr++;
      if (lsb_ok) begin
        seen_l = 1; lsb_req = 1'b0;
        check("rdy_rdata", 64'(lsb_rdata), 64'(exp_l));
        check("rdy_lat_ext", 64'(k > 6), 64'(1));
      end
    end
    if (!seen_l) check("rdy_timeout", 64'(0), 64'(1));
    check("rdy_no_wr", 64'(nwr), 64'(0));
    @(negedge clk);

    // Reset during a word load aborts it silently.
    wlog.delete();
    lsb_op = OP_LW; lsb_addr = 32'h500; lsb_req = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; lsb_req = 1'b0;
    check("abort_ok", 64'(lsb_ok), 64'(0));
    check("abort_wr", 64'(mem_wr), 64'(0));
    nok = 0;
    repeat (8) begin
      @(negedge clk);
      if (lsb_ok) nok++;
    end
    check("abort_no_ok", 64'(nok), 64'(0));
    run_lsb(OP_SW, 32'h500, 32'hCAFEF00D, 0);
    run_lsb(OP_LW, 32'h500, '0, 0);

    // Randomized mix of loads, stores and fetches.
    for (int t = 0; t < 60; t++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 8);
      a = 32'h1000 + 32'($urandom_range(0, 63));
      if (r == 8) run_if(a);
      else run_lsb(ops[r], a, $urandom, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
